// File: rtl/perf_pkg.sv
// Shared register map, CTRL bit positions and pass code for the performance monitor.
package perf_pkg;

    localparam logic [7:0] CTRL_ADDR    = 8'h00;
    localparam logic [7:0] CONSOLE_ADDR = 8'h01;
    localparam logic [7:0] TOHOST_ADDR  = 8'h02;
    localparam logic [7:0] SNAP_ADDR    = 8'h03;
    localparam logic [7:0] CNT_BASE     = 8'h10;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int CTRL_FINI_BIT  = 2;

    localparam logic [31:0] PASS_CODE = 32'h0002_0000;

    // CLEAR is a write-only pulse, so its bit always reads back as zero.
    function automatic logic [31:0] ctrl_word(input logic run, input logic fini);
        logic [31:0] w;
        w = '0;
        w[CTRL_RUN_BIT]  = run;
        w[CTRL_FINI_BIT] = fini;
        return w;
    endfunction

endpackage

// File: rtl/perf_if.sv
// CPU data-bus slave port of the performance monitor.
interface perf_if;
    logic        sel_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;

    modport master (output sel_i, we_i, addr_i, wdata_i, input rdata_o, rvalid_o);
    modport slave  (input sel_i, we_i, addr_i, wdata_i, output rdata_o, rvalid_o);
endinterface

// File: rtl/perf_cnt.sv
// Single wrapping event counter; clear takes priority over increment.
module perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Performance counters plus console/tohost MMIO on the CPU data bus.
// Optional PERF_SNAPSHOT_EN adds a SNAP register and per-counter shadow copies.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_CNT = 5,
    parameter int CNT_W   = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_CNT-1:0] evt_i,
    perf_if.slave              bus,
    output logic               con_valid_o,
    output logic [7:0]         con_data_o,
    output logic               fini_o,
    output logic [31:0]        exit_code_o
);

    logic             wr;
    logic             rd;
    logic             run;
    logic             fini;
    logic             clear;
    logic [31:0]      exit_code;
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [7:0]       addr_off;
    logic [63:0]      sel_cnt;
    logic             cnt_match;
    logic [31:0]      rd_mux;
    logic             con_wr;

    assign wr       = bus.sel_i && bus.we_i;
    assign rd       = bus.sel_i && !bus.we_i;
    assign clear    = wr && (bus.addr_i == CTRL_ADDR) && bus.wdata_i[CTRL_CLEAR_BIT];
    assign con_wr   = wr && (bus.addr_i == CONSOLE_ADDR) && !fini;
    assign addr_off = bus.addr_i - CNT_BASE;

    assign fini_o      = fini;
    assign exit_code_o = exit_code;

    // fini is registered, so an event in the TOHOST write cycle still counts.
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk_i),
            .rst   (rst_i),
            .inc   (evt_i[g] && run && !fini),
            .clear (clear),
            .count (cnt[g])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic             snap_wr;
    logic [CNT_W-1:0] shadow [NUM_CNT];

    assign snap_wr = wr && (bus.addr_i == SNAP_ADDR);

    // Shadows sample the registered counters, so a same-cycle CLEAR is not yet visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
        end else if (snap_wr) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= cnt[i];
        end
    end
`else
    logic [31:0] hi_latch;
`endif

    always_comb begin
        sel_cnt   = '0;
        cnt_match = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.addr_i >= CNT_BASE && int'(addr_off[7:1]) == i) begin
                cnt_match = 1'b1;
`ifdef PERF_SNAPSHOT_EN
                sel_cnt   = 64'(shadow[i]);
`else
                sel_cnt   = 64'(cnt[i]);
`endif
            end
        end

        rd_mux = '0;
        if (bus.addr_i == CTRL_ADDR) begin
            rd_mux = ctrl_word(run, fini);
        end else if (bus.addr_i == TOHOST_ADDR) begin
            rd_mux = exit_code;
        end else if (cnt_match) begin
`ifdef PERF_SNAPSHOT_EN
            rd_mux = addr_off[0] ? sel_cnt[63:32] : sel_cnt[31:0];
`else
            rd_mux = addr_off[0] ? hi_latch : sel_cnt[31:0];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.rdata_o  <= '0;
            bus.rvalid_o <= 1'b0;
            con_valid_o  <= 1'b0;
            con_data_o   <= '0;
            run          <= 1'b1;
            fini         <= 1'b0;
            exit_code    <= '0;
`ifndef PERF_SNAPSHOT_EN
            hi_latch     <= '0;
`endif
        end else begin
            bus.rvalid_o <= rd;
            if (rd) bus.rdata_o <= rd_mux;
`ifndef PERF_SNAPSHOT_EN
            // LO read freezes the matching high word for the following HI read.
            if (rd && cnt_match && !addr_off[0]) hi_latch <= sel_cnt[63:32];
`endif
            con_valid_o <= con_wr;
            if (con_wr) con_data_o <= bus.wdata_i[7:0];
            if (wr && bus.addr_i == CTRL_ADDR) run <= bus.wdata_i[CTRL_RUN_BIT];
            if (wr && bus.addr_i == TOHOST_ADDR) begin
                fini      <= 1'b1;
                exit_code <= bus.wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: counting, tear-free reads, clear, console, tohost, reset.
module tb_perf_monitor;
    import perf_pkg::*;

    localparam int NUM_CNT = 5;
    localparam int CNT_W   = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_CNT-1:0] evt = '0;
    logic               con_valid;
    logic [7:0]         con_data;
    logic               fini;
    logic [31:0]        exit_code;

    int n_checks = 0;
    int n_pass   = 0;

    perf_if bus ();

    perf_monitor #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .evt_i       (evt),
        .bus         (bus),
        .con_valid_o (con_valid),
        .con_data_o  (con_data),
        .fini_o      (fini),
        .exit_code_o (exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.sel_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        step();
        bus.sel_i   = 1'b0;
        bus.we_i    = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.sel_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = a;
        step();
        bus.sel_i  = 1'b0;
        check({tag, "_rvalid"}, 64'(bus.rvalid_o), 64'd1);
        check(tag, 64'(bus.rdata_o), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sel_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_rdata", 64'(bus.rdata_o), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("rst_con_valid", 64'(con_valid), 64'd0);
        check("rst_con_data", 64'(con_data), 64'd0);
        check("rst_fini", 64'(fini), 64'd0);
        check("rst_exit", 64'(exit_code), 64'd0);
        bus_read("rst_ctrl", CTRL_ADDR, 32'h1);
        check("rvalid_single", 64'(bus.rvalid_o), 64'd1);
        step();
        check("rvalid_drop", 64'(bus.rvalid_o), 64'd0);
        check("rdata_hold", 64'(bus.rdata_o), 64'h1);

        // 100 events on counter 0
        evt[0] = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        evt = '0;
        bus_read("cnt0_lo_100", 8'h10, 32'd100);
        bus_read("cnt0_hi_100", 8'h11, 32'd0);
        bus_read("cnt1_lo_0", 8'h12, 32'd0);

        // 32-bit carry into the high word
        force dut.g_cnt[1].u_cnt.count = 64'h0000_0000_FFFF_FFFF;
        step();
        release dut.g_cnt[1].u_cnt.count;
        evt[1] = 1'b1;
        step();
        evt = '0;
        bus_read("cnt1_lo_wrap", 8'h12, 32'h0000_0000);
        bus_read("cnt1_hi_wrap", 8'h13, 32'h0000_0001);

        // event in the LO read cycle: LO sees pre-event value, HI stays latched
        force dut.g_cnt[1].u_cnt.count = 64'h0000_0000_FFFF_FFFF;
        step();
        release dut.g_cnt[1].u_cnt.count;
        evt[1] = 1'b1;
        bus_read("cnt1_lo_tear", 8'h12, 32'hFFFF_FFFF);
        evt = '0;
        bus_read("cnt1_hi_tear", 8'h13, 32'h0000_0000);
        bus_read("cnt1_lo_live", 8'h12, 32'h0000_0000);
        bus_read("cnt1_hi_live", 8'h13, 32'h0000_0001);

        // CLEAR with events on every input: clear wins, then counting resumes
        evt = '1;
        bus_write(CTRL_ADDR, 32'h3);
        bus_read("clr_cnt0", 8'h10, 32'd0);
        bus_read("clr_cnt1", 8'h12, 32'd1);
        bus_read("clr_cnt4", 8'h18, 32'd2);
        evt = '0;
        bus_read("clr_ctrl", CTRL_ADDR, 32'h1);

        // RUN=0 stops counting
        bus_write(CTRL_ADDR, 32'h0);
        evt[2] = 1'b1;
        repeat (5) step();
        evt = '0;
        bus_read("run0_cnt2", 8'h14, 32'd3);
        bus_read("run0_ctrl", CTRL_ADDR, 32'h0);
        bus_write(CTRL_ADDR, 32'h1);

        // unmapped reads
        bus_read("unmap_05", 8'h05, 32'd0);
        bus_read("unmap_1a", 8'h1A, 32'd0);
        bus_read("unmap_snap_rd", SNAP_ADDR, 32'd0);

        // back-to-back console writes
        bus.sel_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = CONSOLE_ADDR;
        bus.wdata_i = 32'h48;
        step();
        check("con_h_valid", 64'(con_valid), 64'd1);
        check("con_h_data", 64'(con_data), 64'h48);
        bus.wdata_i = 32'h69;
        step();
        bus.sel_i = 1'b0;
        bus.we_i  = 1'b0;
        check("con_i_valid", 64'(con_valid), 64'd1);
        check("con_i_data", 64'(con_data), 64'h69);
        step();
        check("con_idle", 64'(con_valid), 64'd0);

        // TOHOST: event in the write cycle counts, later events do not
        evt[0] = 1'b1;
        bus_write(TOHOST_ADDR, PASS_CODE);
        check("fini_rise", 64'(fini), 64'd1);
        check("exit_pass", 64'(exit_code), 64'(PASS_CODE));
        repeat (5) step();
        bus_read("fini_cnt0", 8'h10, 32'd4);
        evt = '0;
        bus_write(CONSOLE_ADDR, 32'h58);
        check("fini_con_drop", 64'(con_valid), 64'd0);
        bus_read("tohost_rd", TOHOST_ADDR, PASS_CODE);
        bus_read("fini_ctrl", CTRL_ADDR, 32'h5);
        bus_write(TOHOST_ADDR, 32'h1);
        check("exit_update", 64'(exit_code), 64'h1);
        check("fini_sticky", 64'(fini), 64'd1);

        // reset during a pending read
        bus.sel_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = TOHOST_ADDR;
        rst        = 1'b1;
        step();
        bus.sel_i = 1'b0;
        rst       = 1'b0;
        check("mid_rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("mid_rst_rdata", 64'(bus.rdata_o), 64'd0);
        check("mid_rst_fini", 64'(fini), 64'd0);
        check("mid_rst_exit", 64'(exit_code), 64'd0);
        bus_read("mid_rst_cnt0", 8'h10, 32'd0);
        bus_read("mid_rst_ctrl", CTRL_ADDR, 32'h1);

`ifdef PERF_SNAPSHOT_EN
        evt[0] = 1'b1;
        repeat (10) step();
        evt = '0;
        bus_write(SNAP_ADDR, 32'h0);
        evt[0] = 1'b1;
        repeat (5) step();
        evt = '0;
        bus_read("snap_lo", 8'h10, 32'd10);
        bus_read("snap_hi", 8'h11, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable, parametrised performance-counter and simulation-control block on the CPU data bus. It counts up to NUM_CNT event streams (cycles, retired instructions, branch predictions and mispredictions, stalls, etc.) in wide counters, exposes them as 32-bit read-only registers, and owns the console and tohost MMIO registers. Software can read the counters on hardware as well as in simulation, and the bench ends a run on `fini_o`.

## Interface
- NUM_CNT, 5, number of counters/event inputs (1..32)
- CNT_W, 64, counter width (32..64); high word is zero-extended
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- evt_i  in  NUM_CNT  per-cycle event strobes; bit i increments counter i
- sel_i  in  1  block selected by the external address decode
- we_i  in  1  write (1) / read (0) when sel_i
- addr_i  in  8  word offset inside the block
- wdata_i  in  32  write data
- rdata_o  out  32  read data
- rvalid_o  out  1  rdata_o valid
- con_valid_o  out  1  console byte strobe
- con_data_o  out  8  console byte
- fini_o  out  1  sticky finish flag
- exit_code_o  out  32  value written to TOHOST

## Operation
- Register map (word offsets):
  - 0x00 CTRL, RW. Bit0 RUN, reset 1. Bit1 CLEAR, write-1 pulse, reads 0. Bit2 FINI, read-only.
  - 0x01 CONSOLE, WO. Write emits wdata_i[7:0].
  - 0x02 TOHOST, RW. Write sets FINI and stores wdata_i as the exit code. Reads return the exit code.
  - 0x03 SNAP, WO. Present only with the macro.
  - 0x10+2i CNTi_LO.
  - 0x11+2i CNTi_HI.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Counting: counter i += 1 when evt_i[i] && RUN && !FINI. Counters wrap modulo 2^CNT_W without saturating.
- CLEAR zeroes all counters. If CLEAR and an event land in the same cycle, CLEAR wins and the counter reads 0.
- Tear-free 64-bit read: reading CNTi_LO latches counter i's high word into one shared hi_latch. Any CNTx_HI read returns hi_latch. Software must read LO then HI.
- FINI is sticky until reset. After FINI:
  - counters freeze;
  - CONSOLE writes are dropped;
  - further TOHOST writes update exit_code_o.
- Bench convention: exit code 0x00020000 means pass.
- CTRL writes with CLEAR=1 also update RUN from the same write.

## Timing
- Writes take effect at the clock edge where sel_i && we_i. A counter value sampled in the following cycle reflects the write.
- Read latency is 1 cycle. rvalid_o pulses for 1 cycle, the cycle after sel_i && !we_i.
- rdata_o holds its last value while rvalid_o=0.
- A counter read returns the value before any event in the same cycle as the request.
- con_valid_o is a 1-cycle pulse, the cycle after the CONSOLE write. Back-to-back writes give back-to-back pulses.
- fini_o rises the cycle after the TOHOST write. An event in that same write cycle is still counted.
- Reset values:
  - rdata_o=0, rvalid_o=0, con_valid_o=0, con_data_o=0
  - fini_o=0, exit_code_o=0
  - all counters, hi_latch and shadows = 0, RUN=1
- Reset asserted mid-operation: everything returns to reset values on the next edge. A pending read produces no rvalid_o.

## Configuration
- PERF_SNAPSHOT_EN defined:
  - A SNAP write copies all counters atomically into shadow registers in one cycle.
  - CNTi_LO and CNTi_HI read the shadow directly. hi_latch is unused.
  - SNAP in the same cycle as CLEAR captures the pre-clear values.
- PERF_SNAPSHOT_EN undefined:
  - No shadow registers are built. SNAP is unmapped.
  - Counter reads use the live value and the hi_latch scheme.

## Structure
- Package perf_pkg holds:
  - register offset constants (CTRL, CONSOLE, TOHOST, SNAP, CNT_BASE);
  - CTRL bit indices;
  - PASS_CODE = 32'h00020000.
- Sub-module perf_cnt: one CNT_W counter with inc/clear inputs and clear priority, generated NUM_CNT times.
- Top level holds the register decode, read mux, hi_latch, console/FINI logic and optional shadows.

## Test plan
- Hold evt_i[0]=1 for 100 cycles after reset, then read CNT0_LO, CNT0_HI -> 100, 0, each with rvalid_o one cycle after the request.
- Preload counter 1 to 0xFFFF_FFFF, pulse evt_i[1], read LO then HI -> 0x0000_0000, 0x0000_0001. An event between the two reads does not change the HI value returned.
- Write CTRL=0x3 while evt_i=all-ones -> all counters read 0 the next cycle and resume counting (1 the cycle after).
- Write CONSOLE 'H' then 'i' on consecutive cycles -> two consecutive con_valid_o pulses with 0x48, 0x69.
- Write TOHOST=0x00020000 -> fini_o=1 next cycle and exit_code_o=0x00020000. Counters stop despite events. A later CONSOLE write gives no pulse.
- With PERF_SNAPSHOT_EN: count 10 events, write SNAP, count 5 more, read CNT0_LO -> 10.
